// File: rtl/pack_pkg.sv
// Shared types and constants for the pack_fifo trace frame queue.
package pack_pkg;

  localparam int unsigned FRAME_W = 128;

  typedef logic [FRAME_W-1:0] frame_t;

  localparam bit POLICY_DROP_NEW = 1'b0;
  localparam bit POLICY_DROP_OLD = 1'b1;

endpackage

// File: rtl/pack_fifo_ram.sv
// Simple dual-port frame store: synchronous write, registered write-first read.
module pack_fifo_ram
  import pack_pkg::*;
#(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A write landing on the slot being read is forwarded, so a push into an
  // empty queue reaches the output on the very next edge.
  always_comb begin
    rdata_d = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pack_fifo.sv
// First-word-fall-through TPIU frame queue with overflow policy, level and drop stats.
// Optional peak-level tracking on MaxLevel is enabled by defining PACK_FIFO_STATS_EN.
module pack_fifo
  import pack_pkg::*;
#(
  parameter int unsigned FRAME_W     = pack_pkg::FRAME_W,
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter bit          DROP_OLDEST = POLICY_DROP_NEW,
  parameter int unsigned HWM         = (1 << DEPTH_LOG2) - 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PkAvail,
  input  logic [FRAME_W-1:0]    Packet,
  output logic [FRAME_W-1:0]    Frame,
  output logic                  FrameReady,
  input  logic                  FrameNext,
  output logic                  DataOverf,
  input  logic                  OverfClr,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  HighWater,
  output logic [CNT_W-1:0]      DropCnt,
  output logic [DEPTH_LOG2:0]   MaxLevel
);

  localparam int unsigned           DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned           LVL_W     = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]      DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]      HWM_L     = LVL_W'(HWM);
  localparam bit                    OVERWRITE = (DROP_OLDEST == POLICY_DROP_OLD);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  hw_q, hw_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_W-1:0]      drop_q, drop_d;

  logic full, empty, pop, push_ok, ovf_evt, wr_en, rd_adv;

  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign pop     = FrameNext && !empty;
  assign push_ok = PkAvail && (!full || pop);
  assign ovf_evt = PkAvail && full && !pop;
  // Overwrite-oldest writes into the head slot and advances both pointers.
  assign wr_en   = push_ok || (ovf_evt && OVERWRITE);
  assign rd_adv  = pop || (ovf_evt && OVERWRITE);

  always_comb begin
    wr_ptr_d = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_adv ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push_ok) begin
      level_d = level_q - 1'b1;
    end
    hw_d = (level_d >= HWM_L);
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (ovf_evt) begin
      ovf_d  = 1'b1;
      drop_d = OverfClr ? CNT_W'(1) : ((drop_q == '1) ? drop_q : drop_q + 1'b1);
    end else if (OverfClr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hw_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hw_q     <= hw_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Reading at the next head keeps Frame registered yet always current.
  pack_fifo_ram #(
    .WIDTH  (FRAME_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (Packet),
    .raddr_i (rd_ptr_d),
    .rdata_o (Frame)
  );

`ifdef PACK_FIFO_STATS_EN
  logic [LVL_W-1:0] max_lvl_q, max_lvl_d;

  always_comb begin
    max_lvl_d = max_lvl_q;
    if (OverfClr) begin
      max_lvl_d = level_q;
    end else if (level_q > max_lvl_q) begin
      max_lvl_d = level_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_lvl_q <= '0;
    end else begin
      max_lvl_q <= max_lvl_d;
    end
  end

  assign MaxLevel = max_lvl_q;
`else
  assign MaxLevel = '0;
`endif

  assign FrameReady = !empty;
  assign Level      = level_q;
  assign HighWater  = hw_q;
  assign DataOverf  = ovf_q;
  assign DropCnt    = drop_q;

endmodule

// File: tb/tb_pack_fifo.sv
// Directed bench: one drop-newest and one drop-oldest (2-bit counter) queue on shared stimulus.
module tb_pack_fifo;
  import pack_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       PkAvail = 1'b0;
  frame_t     Packet = '0;
  logic       FrameNext = 1'b0;
  logic       OverfClr = 1'b0;

  frame_t     frame_n, frame_o;
  logic       rdy_n, rdy_o, ovf_n, ovf_o, hw_n, hw_o;
  logic [3:0] lvl_n, lvl_o, max_n, max_o;
  logic [15:0] drop_n;
  logic [1:0]  drop_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pack_fifo #(
    .FRAME_W(128), .DEPTH_LOG2(3), .DROP_OLDEST(1'b0), .CNT_W(16)
  ) u_new (
    .clk(clk), .rst(rst), .PkAvail(PkAvail), .Packet(Packet),
    .Frame(frame_n), .FrameReady(rdy_n), .FrameNext(FrameNext),
    .DataOverf(ovf_n), .OverfClr(OverfClr), .Level(lvl_n),
    .HighWater(hw_n), .DropCnt(drop_n), .MaxLevel(max_n)
  );

  pack_fifo #(
    .FRAME_W(128), .DEPTH_LOG2(3), .DROP_OLDEST(1'b1), .CNT_W(2)
  ) u_old (
    .clk(clk), .rst(rst), .PkAvail(PkAvail), .Packet(Packet),
    .Frame(frame_o), .FrameReady(rdy_o), .FrameNext(FrameNext),
    .DataOverf(ovf_o), .OverfClr(OverfClr), .Level(lvl_o),
    .HighWater(hw_o), .DropCnt(drop_o), .MaxLevel(max_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic frame_t frm(input int k);
    logic [31:0] w;
    w = 32'hA5A5_0000 ^ 32'(k);
    return {w, ~w, w, 32'(k)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input frame_t f);
    Packet  = f;
    PkAvail = 1'b1;
    cycle();
    PkAvail = 1'b0;
  endtask

  task automatic pop();
    FrameNext = 1'b1;
    cycle();
    FrameNext = 1'b0;
  endtask

  task automatic check_both_level(input string tag, input int exp);
    check({tag, "_lvl_new"}, lvl_n, 128'(exp));
    check({tag, "_lvl_old"}, lvl_o, 128'(exp));
  endtask

  initial begin
    frame_t basic;
    basic = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_AA10;

    // Reset state
    cycle(); cycle();
    check_both_level("rst", 0);
    check("rst_rdy", rdy_n, 0);
    check("rst_frame", frame_n, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_hw", hw_n, 0);
    check("rst_drop", drop_n, 0);
    check("rst_max", max_n, 0);
    #3 rst = 1'b1;
    cycle();

    // Basic FWFT
    push(basic);
    check("fwft_rdy", rdy_n, 1);
    check("fwft_frame", frame_n, basic);
    check("fwft_frame_old", frame_o, basic);
    check_both_level("fwft", 1);
    pop();
    check("pop_rdy", rdy_n, 0);
    check_both_level("pop", 0);
    pop();
    check("pop_empty_rdy", rdy_o, 0);
    check_both_level("pop_empty", 0);

    // Fill 1..10, no pops
    for (int k = 1; k <= 10; k++) begin
      push(frm(k));
      check_both_level($sformatf("fill%0d", k), (k > 8) ? 8 : k);
      if (k == 1) check("fill1_head", frame_n, frm(1));
      if (k == 5) check("fill5_hw", hw_n, 0);
      if (k == 6) check("fill6_hw", hw_o, 1);
      if (k == 8) check("fill8_ovf", ovf_n, 0);
      if (k == 9) begin
        check("fill9_ovf_new", ovf_n, 1);
        check("fill9_ovf_old", ovf_o, 1);
        check("fill9_drop_new", drop_n, 1);
        check("fill9_drop_old", drop_o, 1);
        check("fill9_head_new", frame_n, frm(1));
        check("fill9_head_old", frame_o, frm(2));
      end
      if (k == 10) begin
        check("fill10_drop_new", drop_n, 2);
        check("fill10_drop_old", drop_o, 2);
        check("fill10_head_old", frame_o, frm(3));
      end
    end

    // Drain: new returns 1..8, old returns 3..10
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_new", i), frame_n, frm(i + 1));
      check($sformatf("drain%0d_old", i), frame_o, frm(i + 3));
      pop();
    end
    check_both_level("drained", 0);
    check("drained_rdy", rdy_o, 0);
    check("drained_hw", hw_n, 0);
    check("drained_ovf_sticky", ovf_n, 1);

    // Refill, saturate the 2-bit counter, then clear vs overflow
    for (int k = 20; k <= 27; k++) push(frm(k));
    check_both_level("refill", 8);
    push(frm(30));
    check("sat1_drop_new", drop_n, 3);
    check("sat1_drop_old", drop_o, 3);
    push(frm(31));
    check("sat2_drop_new", drop_n, 4);
    check("sat2_drop_old", drop_o, 3);
    OverfClr = 1'b1;
    push(frm(28));
    OverfClr = 1'b0;
    check("clrovf_ovf_new", ovf_n, 1);
    check("clrovf_ovf_old", ovf_o, 1);
    check("clrovf_drop_new", drop_n, 1);
    check("clrovf_drop_old", drop_o, 1);
    check("clrovf_head_new", frame_n, frm(20));
    check("clrovf_head_old", frame_o, frm(23));
    OverfClr = 1'b1;
    cycle();
    OverfClr = 1'b0;
    check("clr_ovf", ovf_n, 0);
    check("clr_drop_new", drop_n, 0);
    check("clr_drop_old", drop_o, 0);

    // Full with simultaneous push and pop
    Packet = frm(29); PkAvail = 1'b1; FrameNext = 1'b1;
    cycle();
    PkAvail = 1'b0; FrameNext = 1'b0;
    check_both_level("pushpop", 8);
    check("pushpop_ovf_new", ovf_n, 0);
    check("pushpop_ovf_old", ovf_o, 0);
    check("pushpop_drop_new", drop_n, 0);
    check("pushpop_head_new", frame_n, frm(21));
    check("pushpop_head_old", frame_o, frm(24));

    // Down to 5, restart peak tracking there
    pop(); pop(); pop();
    check_both_level("lvl5", 5);
    check("lvl5_head_new", frame_n, frm(24));
    check("lvl5_head_old", frame_o, frm(27));
    check("lvl5_hw", hw_n, 0);
    OverfClr = 1'b1;
    cycle();
    OverfClr = 1'b0;
    cycle();
`ifdef PACK_FIFO_STATS_EN
    check("max_before_rst", max_n, 5);
`else
    check("max_tied", max_n, 0);
`endif

    // Asynchronous reset away from any clock edge
    #2 rst = 1'b0;
    #1;
    check_both_level("async_rst", 0);
    check("async_rst_rdy_new", rdy_n, 0);
    check("async_rst_rdy_old", rdy_o, 0);
    check("async_rst_frame", frame_o, 0);
    check("async_rst_max", max_n, 0);
    #1 rst = 1'b1;
    cycle();
    check("post_rst_rdy", rdy_n, 0);
    push(frm(40));
    check("post_rst_push_rdy", rdy_n, 1);
    check("post_rst_push_frame", frame_o, frm(40));
    check_both_level("post_rst_push", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pack_fifo.md
Name: pack_fifo

Overview:
- Parametrised successor to the single-slot packet buffer.
- Sits between the trace frame decoder (traceIF, on the clk side) and the output handler.
- Queues fixed-width TPIU frames in a 2^DEPTH_LOG2-entry first-word-fall-through FIFO.
- Adds a selectable overflow policy, occupancy and high-water reporting, and a saturating drop counter.

Parameters:
- FRAME_W, 128: frame width in bits.
- DEPTH_LOG2, 3: log2 of the entry count; DEPTH = 2^DEPTH_LOG2, legal range 1..8.
- DROP_OLDEST, 0: overflow policy. 0 discards the incoming frame; 1 overwrites the oldest entry.
- HWM, DEPTH-2: HighWater asserts when Level >= HWM.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
- PkAvail  in  1  single-cycle strobe; Packet is valid this cycle.
- Packet  in  FRAME_W  incoming frame.
- Frame  out  FRAME_W  head-of-queue frame; valid while FrameReady=1.
- FrameReady  out  1  FIFO non-empty.
- FrameNext  in  1  pop strobe; consumed only when FrameReady=1.
- DataOverf  out  1  sticky overflow flag.
- OverfClr  in  1  clears DataOverf and DropCnt.
- Level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- HighWater  out  1  registered flag, Level >= HWM.
- DropCnt  out  CNT_W  frames lost to overflow, saturating.
- MaxLevel  out  DEPTH_LOG2+1  peak occupancy (see Optional Feature).

Behaviour:
- Reset (rst=0), asynchronous:
  - rd/wr pointers = 0, Level = 0, FrameReady = 0, Frame = 0.
  - DataOverf = 0, HighWater = 0, DropCnt = 0, MaxLevel = 0.
  - RAM contents are not reset.
- Storage: DEPTH x FRAME_W array. Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Level is tracked explicitly, not derived from pointers.
- Push: PkAvail=1 and Level<DEPTH writes Packet at wr_ptr and increments wr_ptr. The frame is visible on Frame with FrameReady=1 on the cycle after the strobe, so latency is 1 clk when empty.
- Pop: FrameNext=1 and FrameReady=1 increments rd_ptr.
  - Frame updates to the next entry on the following edge.
  - FrameNext while empty is ignored; no state change.
- Frame is registered and always reflects the entry at rd_ptr. A push into an empty FIFO loads Frame directly (bypass) so the 1-cycle latency holds.
- Simultaneous push+pop:
  - Not full: both occur, Level unchanged.
  - Full: both occur, no overflow, Level stays DEPTH.
  - Empty: push occurs; FrameNext is ignored.
- Overflow (push with Level==DEPTH and no pop):
  - DROP_OLDEST=0: Packet is discarded; pointers and Level are unchanged.
  - DROP_OLDEST=1: Packet is written at wr_ptr, and both wr_ptr and rd_ptr advance; Level stays DEPTH. The new head appears on Frame next cycle.
  - Either policy: DataOverf<=1 and DropCnt increments, saturating at 2^CNT_W-1.
- OverfClr:
  - DataOverf<=0 and DropCnt<=0.
  - If an overflow occurs in the same cycle, the overflow wins: DataOverf=1, DropCnt=1.
- HighWater and Level are registered and updated with the same edge as the push/pop.
- FIFO state (pointers, Level, DataOverf, DropCnt) has no synchronous flush; only rst clears it. OverfClr clears only DataOverf and DropCnt (and MaxLevel when compiled in).
- Reset mid-operation: all queued frames are lost. FrameReady is low from rst assertion until the first post-reset push.

Optional Feature:
- Macro: PACK_FIFO_STATS_EN.
- Defined: MaxLevel is a register tracking the peak Level since reset or OverfClr, updated the cycle after Level rises. OverfClr sets MaxLevel to the current Level.
- Undefined: MaxLevel is tied to 0 and no register is inferred.

Decomposition:
- Shared package pack_pkg holds:
  - FRAME_W default 128.
  - frame_t typedef, logic [FRAME_W-1:0].
  - Overflow policy constants POLICY_DROP_NEW=0 and POLICY_DROP_OLD=1.
- One natural sub-module: pack_fifo_ram, a simple dual-port DEPTH x FRAME_W array with synchronous write and registered read.
  - Replaces the existing ram.v usage.
  - Pointer, level and flag logic stay in pack_fifo.

Test Plan:
- Basic FWFT (DEPTH_LOG2=3): push frame 128'h...AA10 with no pops -> FrameReady=1 and Frame=128'h...AA10 one clk later, Level=1; FrameNext -> FrameReady=0 next clk, Level=0.
- Fill and drop-new (DROP_OLDEST=0): push frames 1..9 with no pops -> Level=8, DataOverf=1, DropCnt=1; pops return 1..8 in order.
- Drop-old (DROP_OLDEST=1): push frames 1..10 with no pops -> Level=8, DropCnt=2; pops return 3..10.
- Full with simultaneous push+pop: at Level=8, PkAvail and FrameNext in the same cycle -> Level=8, DataOverf stays 0, head advances by one.
- Clear vs overflow: at full, OverfClr with a concurrent overflow push -> DataOverf=1, DropCnt=1; OverfClr alone next cycle -> DataOverf=0, DropCnt=0.
- Async reset mid-stream: rst=0 at Level=5 with no clk edge -> Level=0, FrameReady=0 immediately. With PACK_FIFO_STATS_EN defined, MaxLevel reads 5 before reset and 0 after.
